shared_mul_gf2_arbiter: RTL and testbench
=========================================

# shared_mul_gf2_arbiter

Round-robin scheduler that shares one pipelined masked GF(2^2) multiplier (`shared_mul_gf2`, `PIPELINED=1`) among several requesters inside the masked S-box datapath. It accepts share-wise operands X and Y through a valid/ready handshake and attaches fresh inter-share randomness Z to each issue. It registers the selected operands before the multiplier, then returns the shared product tagged with the requester index after a fixed latency. Idle cycles drive all-zero operands, so shares of different requests never meet in the multiplier's combinational logic.

## Interface
- SHARES, 3, number of Boolean shares (d+1)
- REQUESTERS, 4, number of requesters, ≥2, power of two
- LATENCY, 1, cycles from multiplier input to valid `_MulQxDI`
- ClkxCI  in  1  clock, rising edge
- RstxRI  in  1  reset, synchronous, active-high
- ReqValidxSI  in  REQUESTERS  request valid, one bit per requester
- ReqReadyxSO  out  REQUESTERS  grant/accept, one-hot or zero
- _ReqXxDI  in  REQUESTERS*2*SHARES  X operands; requester r at [r*2*SHARES +: 2*SHARES]; share i at [i*2+1:i*2]
- _ReqYxDI  in  REQUESTERS*2*SHARES  Y operands, same packing
- RandValidxSI  in  1  fresh randomness available
- _RandxDI  in  SHARES*(SHARES-1)  randomness Z
- RandReadyxSO  out  1  randomness consumed this cycle
- _MulXxDO, _MulYxDO  out  2*SHARES  registered multiplier operands
- _MulZxDO  out  SHARES*(SHARES-1)  registered randomness
- _MulQxDI  in  2*SHARES  multiplier result
- RspValidxSO  out  1  response valid, one cycle
- RspIdxDO  out  log2(REQUESTERS)  requester index of the response
- _RspQxDO  out  2*SHARES  shared product, same packing
- IdlexSO  out  1  high when no operation is in flight

## Operation
- Issue condition: at least one ReqValidxSI bit high and RandValidxSI=1. When it holds, exactly one grant is made, and ReqReadyxSO[g] and RandReadyxSO go high in the same cycle. Both are combinational from the valid inputs and the pointer.
- Without RandValidxSI, nothing is granted: ReqReadyxSO=0 and RandReadyxSO=0. An operation is never issued with stale Z.
- Round-robin pointer P (log2(REQUESTERS) bits, reset 0): grant goes to the first valid requester scanning P, P+1, … modulo REQUESTERS. After a grant to g, P ← (g+1) mod REQUESTERS. P is unchanged when nothing is granted.
- Issue register, updated every cycle:
  - On grant: loads the X/Y shares of requester g and Z.
  - Otherwise: loads all zeros.
  - Its outputs are `_MulXxDO`, `_MulYxDO`, `_MulZxDO`. No combinational path exists from `_ReqXxDI`/`_ReqYxDI` to the multiplier.
- Tag pipeline: a shift register of depth 1+LATENCY carries {valid, index}. The stage-0 valid is the issue flag. At the output, RspValidxSO=valid, RspIdxDO=index, and `_RspQxDO` = `_MulQxDI` passed through combinationally.
- When RspValidxSO=0, `_RspQxDO` is forced to zero.
- Responses have no backpressure. Requesters must sink them.
- IdlexSO = NOR of all tag-pipeline valid bits.
- Requester contract: a requester holds its operands stable while ReqValidxSI is high and ReqReadyxSO is low. Dropping ReqValidxSI before a grant is allowed.

## Timing
- Throughput: one issue per cycle when randomness is continuous.
- Latency: handshake in cycle t leads to the operands on `_Mul*xDO` in cycle t+1, and RspValidxSO=1 in cycle t+1+LATENCY (t+2 by default).
- Responses leave in issue order. Back-to-back issues give back-to-back responses.
- Reset (RstxRI=1 at a rising edge): on the next cycle, all registered outputs are zero, P=0, all tag valids are 0, and IdlexSO=1.
- During reset, ReqReadyxSO=0 and RandReadyxSO=0.
- Reset mid-operation drops all in-flight operations. No response is produced for them, and none appears after reset is released.
- A request whose valid and grant coincide with the reset cycle is not accepted.
- Simultaneous requests: only the requester chosen by the round-robin scan is granted. The others keep ReqReadyxSO=0.
- Pointer wrap: a grant to REQUESTERS-1 sets P=0.

## Test plan
1. Reset release, no requests: with RstxRI=1 for 2 cycles then 0, check all outputs 0 and IdlexSO=1. Then drive req0 with X share0=2'b10 and Y share0=2'b11, other shares 0, Z=0 → RspValidxSO=1, RspIdxDO=0 exactly 2 cycles after the grant. The XOR of the `_RspQxDO` shares must equal the GF(2^2) product from the reference model.
2. All 4 requesters valid continuously with RandValidxSI=1 → grants rotate 0,1,2,3,0,…, one per cycle. Responses arrive in the same order at t+2 with IdlexSO=0 throughout.
3. Randomness starvation: all requesters valid, RandValidxSI toggling 1,0,1 → grants and RandReadyxSO only in the valid cycles, the pointer is held across the gap, and `_MulXxDO`=0 in the cycle after a stall.
4. Only req3 valid, then req0 and req3 together → req3 is granted first, then req0 (P wrapped to 0). Req3 is granted again only after req0.
5. Reset mid-flight: issue to req1, then assert RstxRI in the next cycle → no RspValidxSO ever appears for req1, and IdlexSO=1 after reset.
6. Exhaustive masking check: for all 16 (X,Y) pairs with random SHARES=3 sharings and random Z → the recombined response equals the model product for every pair, and the `_MulXxDO` shares equal those of the granted requester only.

Source files
------------

// File: rtl/shared_mul_gf2_arbiter.sv
// Round-robin scheduler sharing one pipelined masked GF(2^2) multiplier
// among several requesters. Operands are registered before the multiplier.
// Idle cycles load all-zero operands so that shares of different requests
// never meet in the multiplier's combinational logic. Results come back
// tagged with the requester index after a fixed latency.
module shared_mul_gf2_arbiter #(
   parameter int unsigned SHARES     = 3,
   parameter int unsigned REQUESTERS = 4,
   parameter int unsigned LATENCY    = 1
) (
   input  logic                                ClkxCI,
   input  logic                                RstxRI,
   input  logic [REQUESTERS-1:0]               ReqValidxSI,
   output logic [REQUESTERS-1:0]               ReqReadyxSO,
   input  logic [REQUESTERS*2*SHARES-1:0]      _ReqXxDI,
   input  logic [REQUESTERS*2*SHARES-1:0]      _ReqYxDI,
   input  logic                                RandValidxSI,
   input  logic [SHARES*(SHARES-1)-1:0]        _RandxDI,
   output logic                                RandReadyxSO,
   output logic [2*SHARES-1:0]                 _MulXxDO,
   output logic [2*SHARES-1:0]                 _MulYxDO,
   output logic [SHARES*(SHARES-1)-1:0]        _MulZxDO,
   input  logic [2*SHARES-1:0]                 _MulQxDI,
   output logic                                RspValidxSO,
   output logic [$clog2(REQUESTERS)-1:0]       RspIdxDO,
   output logic [2*SHARES-1:0]                 _RspQxDO,
   output logic                                IdlexSO
);

   localparam int unsigned IDX_W = $clog2(REQUESTERS);
   localparam int unsigned DW    = 2 * SHARES;
   localparam int unsigned ZW    = SHARES * (SHARES - 1);

   // Round-robin pointer: first requester examined by the next scan.
   logic [IDX_W-1:0] r_ptr;

   // Issue register feeding the shared multiplier.
   logic [DW-1:0] r_mul_x;
   logic [DW-1:0] r_mul_y;
   logic [ZW-1:0] r_mul_z;

   // Tag pipeline: stage 0 aligns with the issue register, stage LATENCY
   // aligns with the multiplier result.
   logic [LATENCY:0]            r_tag_valid;
   logic [LATENCY:0][IDX_W-1:0] r_tag_idx;

   logic [IDX_W-1:0] w_scan;
   logic             w_found;
   logic [IDX_W-1:0] w_grant_idx;
   logic             w_issue;
   logic [DW-1:0]    w_sel_x;
   logic [DW-1:0]    w_sel_y;

   // Scan requesters starting at the pointer; the first valid one wins.
   always_comb begin
      w_scan      = '0;
      w_found     = 1'b0;
      w_grant_idx = '0;
      for (int unsigned k = 0; k < REQUESTERS; k++) begin
         w_scan = r_ptr + IDX_W'(k);
         if (!w_found && ReqValidxSI[w_scan]) begin
            w_found     = 1'b1;
            w_grant_idx = w_scan;
         end
      end
   end

   // Never issue without fresh randomness, and never while in reset.
   assign w_issue = w_found & RandValidxSI & ~RstxRI;

   // Select the granted requester's operand shares.
   always_comb begin
      w_sel_x = '0;
      w_sel_y = '0;
      for (int unsigned k = 0; k < REQUESTERS; k++) begin
         if (w_grant_idx == IDX_W'(k)) begin
            w_sel_x = _ReqXxDI[k*DW +: DW];
            w_sel_y = _ReqYxDI[k*DW +: DW];
         end
      end
   end

   // One-hot grant toward the requesters, combinational from the valids.
   always_comb begin
      ReqReadyxSO = '0;
      for (int unsigned k = 0; k < REQUESTERS; k++) begin
         ReqReadyxSO[k] = w_issue && (w_grant_idx == IDX_W'(k));
      end
   end

   assign RandReadyxSO = w_issue;

   // Pointer moves past the granted requester; held when nothing issues.
   always_ff @(posedge ClkxCI) begin
      if (RstxRI) begin
         r_ptr <= '0;
      end else if (w_issue) begin
         r_ptr <= w_grant_idx + IDX_W'(1);
      end
   end

   // Issue register: granted shares and randomness, otherwise all zeros.
   always_ff @(posedge ClkxCI) begin
      if (RstxRI) begin
         r_mul_x <= '0;
         r_mul_y <= '0;
         r_mul_z <= '0;
      end else if (w_issue) begin
         r_mul_x <= w_sel_x;
         r_mul_y <= w_sel_y;
         r_mul_z <= _RandxDI;
      end else begin
         r_mul_x <= '0;
         r_mul_y <= '0;
         r_mul_z <= '0;
      end
   end

   // Shift {valid, index} alongside the multiplier pipeline.
   always_ff @(posedge ClkxCI) begin
      if (RstxRI) begin
         r_tag_valid <= '0;
         r_tag_idx   <= '0;
      end else begin
         r_tag_valid[0] <= w_issue;
         r_tag_idx[0]   <= w_issue ? w_grant_idx : '0;
         for (int unsigned s = 1; s <= LATENCY; s++) begin
            r_tag_valid[s] <= r_tag_valid[s-1];
            r_tag_idx[s]   <= r_tag_idx[s-1];
         end
      end
   end

   assign _MulXxDO    = r_mul_x;
   assign _MulYxDO    = r_mul_y;
   assign _MulZxDO    = r_mul_z;
   assign RspValidxSO = r_tag_valid[LATENCY];
   assign RspIdxDO    = r_tag_idx[LATENCY];
   // Product shares are only exposed alongside a valid response.
   assign _RspQxDO    = r_tag_valid[LATENCY] ? _MulQxDI : '0;
   assign IdlexSO     = ~|r_tag_valid;

   // Grants are one-hot or zero and always paired with randomness consumption.
   a_ready_onehot : assert property (@(posedge ClkxCI) $onehot0(ReqReadyxSO));
   a_rand_pair    : assert property (@(posedge ClkxCI) RandReadyxSO == (|ReqReadyxSO));

endmodule

// File: tb/tb_shared_mul_gf2_arbiter.sv
// Bench for shared_mul_gf2_arbiter: stub masked multiplier, table-driven
// arbitration vectors, and a response scoreboard.
module tb_shared_mul_gf2_arbiter;

   localparam int unsigned SH  = 3;
   localparam int unsigned NR  = 4;
   localparam int unsigned LAT = 1;

   logic        clk;
   logic        rst;
   logic [3:0]  req_valid;
   logic [3:0]  req_ready;
   logic [23:0] req_x;
   logic [23:0] req_y;
   logic        rand_valid;
   logic [5:0]  rand_z;
   logic        rand_ready;
   logic [5:0]  mul_x;
   logic [5:0]  mul_y;
   logic [5:0]  mul_z;
   logic [5:0]  mul_q;
   logic        rsp_valid;
   logic [1:0]  rsp_idx;
   logic [5:0]  rsp_q;
   logic        idle;

   shared_mul_gf2_arbiter #(.SHARES(SH), .REQUESTERS(NR), .LATENCY(LAT)) dut (
      .ClkxCI(clk), .RstxRI(rst),
      .ReqValidxSI(req_valid), .ReqReadyxSO(req_ready),
      ._ReqXxDI(req_x), ._ReqYxDI(req_y),
      .RandValidxSI(rand_valid), ._RandxDI(rand_z), .RandReadyxSO(rand_ready),
      ._MulXxDO(mul_x), ._MulYxDO(mul_y), ._MulZxDO(mul_z), ._MulQxDI(mul_q),
      .RspValidxSO(rsp_valid), .RspIdxDO(rsp_idx), ._RspQxDO(rsp_q),
      .IdlexSO(idle)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct { logic [3:0] vld; logic rv; logic [3:0] exp; } arb_vec_t;
   typedef struct { logic [1:0] x; logic [1:0] y; logic [1:0] prod; } mul_vec_t;
   typedef struct { logic [1:0] idx; logic [1:0] prod; int due; } sb_t;

   arb_vec_t   arb_tab[$];
   mul_vec_t   mul_tab[16];
   logic [1:0] prod_tab[16];
   sb_t        sbq[$];
   logic [1:0] px[4];
   logic [1:0] py[4];
   logic [5:0] pend_x, pend_y, pend_z;
   int total = 0;
   int bad   = 0;
   int cyc   = 0;

   // GF(2^2) with x^2+x+1: used only by the multiplier stub.
   function automatic logic [1:0] gf_mul(input logic [1:0] a, input logic [1:0] b);
      logic [1:0] c;
      c[1] = (a[1] & b[0]) ^ (a[0] & b[1]) ^ (a[1] & b[1]);
      c[0] = (a[0] & b[0]) ^ (a[1] & b[1]);
      return c;
   endfunction

   function automatic logic [1:0] recomb(input logic [5:0] s);
      return s[1:0] ^ s[3:2] ^ s[5:4];
   endfunction

   function automatic logic [5:0] share_of(input logic [1:0] v);
      logic [1:0] a, b;
      a = 2'($urandom);
      b = 2'($urandom);
      return {b, a, v ^ a ^ b};
   endfunction

   // Stub output shares mix in fresh noise, so an unmasked idle output is nonzero.
   function automatic logic [5:0] stub_q(input logic [5:0] x, input logic [5:0] y,
                                         input logic [5:0] z);
      logic [1:0] m1, m2;
      m1 = z[1:0] ^ 2'($urandom);
      m2 = z[3:2] ^ 2'($urandom);
      return {m2, m1, gf_mul(recomb(x), recomb(y)) ^ m1 ^ m2};
   endfunction

   // Pipelined multiplier model, one register stage.
   always @(posedge clk) mul_q <= stub_q(mul_x, mul_y, mul_z);

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic drive(input logic [3:0] v, input logic r);
      req_valid  = v;
      rand_valid = r;
      rand_z     = 6'($urandom);
   endtask

   task automatic set_req(input int r, input logic [1:0] x, input logic [1:0] y);
      px[r] = x;
      py[r] = y;
      req_x[r*6 +: 6] = share_of(x);
      req_y[r*6 +: 6] = share_of(y);
   endtask

   // One clock: check grants mid-cycle, then registered outputs after the edge.
   task automatic step(input logic [3:0] exp_ready);
      sb_t e;
      int  g;
      @(negedge clk);
      check("req_ready", 32'(req_ready), 32'(exp_ready));
      check("rand_ready", 32'(rand_ready), 32'(|exp_ready));
      pend_x = '0;
      pend_y = '0;
      pend_z = '0;
      if (!rst && exp_ready != 4'b0) begin
         g = 0;
         for (int k = 0; k < 4; k++) if (exp_ready[k]) g = k;
         pend_x = req_x[g*6 +: 6];
         pend_y = req_y[g*6 +: 6];
         pend_z = rand_z;
         e.idx  = 2'(g);
         e.prod = prod_tab[{px[g], py[g]}];
         e.due  = cyc + 2;
         sbq.push_back(e);
      end
      @(posedge clk);
      cyc++;
      #1;
      if (rst) sbq.delete();
      check("mul_x", 32'(mul_x), 32'(pend_x));
      check("mul_y", 32'(mul_y), 32'(pend_y));
      check("mul_z", 32'(mul_z), 32'(pend_z));
      check("idle", 32'(idle), 32'(sbq.size() == 0));
      if (rsp_valid) begin
         if (sbq.size() == 0) begin
            total++;
            bad++;
            $display("FAIL rsp_unexpected: got idx %0d want no response (cycle %0d)", rsp_idx, cyc);
         end else begin
            e = sbq.pop_front();
            check("rsp_idx", 32'(rsp_idx), 32'(e.idx));
            check("rsp_prod", 32'(recomb(rsp_q)), 32'(e.prod));
            check("rsp_cycle", 32'(cyc), 32'(e.due));
         end
      end else begin
         check("rsp_q_zero", 32'(rsp_q), 32'(0));
         if (sbq.size() > 0 && sbq[0].due <= cyc) begin
            total++;
            bad++;
            $display("FAIL rsp_missing: got no response want idx %0d (cycle %0d)", sbq[0].idx, cyc);
            void'(sbq.pop_front());
         end
      end
   endtask

   initial begin
      // Full GF(2^2) product table, x^2+x+1 polynomial basis.
      mul_tab[0]  = '{2'd0, 2'd0, 2'd0}; mul_tab[1]  = '{2'd0, 2'd1, 2'd0};
      mul_tab[2]  = '{2'd0, 2'd2, 2'd0}; mul_tab[3]  = '{2'd0, 2'd3, 2'd0};
      mul_tab[4]  = '{2'd1, 2'd0, 2'd0}; mul_tab[5]  = '{2'd1, 2'd1, 2'd1};
      mul_tab[6]  = '{2'd1, 2'd2, 2'd2}; mul_tab[7]  = '{2'd1, 2'd3, 2'd3};
      mul_tab[8]  = '{2'd2, 2'd0, 2'd0}; mul_tab[9]  = '{2'd2, 2'd1, 2'd2};
      mul_tab[10] = '{2'd2, 2'd2, 2'd3}; mul_tab[11] = '{2'd2, 2'd3, 2'd1};
      mul_tab[12] = '{2'd3, 2'd0, 2'd0}; mul_tab[13] = '{2'd3, 2'd1, 2'd3};
      mul_tab[14] = '{2'd3, 2'd2, 2'd1}; mul_tab[15] = '{2'd3, 2'd3, 2'd2};
      for (int k = 0; k < 16; k++) prod_tab[{mul_tab[k].x, mul_tab[k].y}] = mul_tab[k].prod;

      // Arbitration vectors, starting with the pointer at 1.
      // Continuous requests: rotation 1,2,3,0,...
      for (int k = 0; k < 8; k++) arb_tab.push_back('{4'b1111, 1'b1, 4'(1 << ((k + 1) % 4))});
      // Randomness starvation: pointer held across gaps.
      arb_tab.push_back('{4'b1111, 1'b1, 4'b0010});
      arb_tab.push_back('{4'b1111, 1'b0, 4'b0000});
      arb_tab.push_back('{4'b1111, 1'b1, 4'b0100});
      arb_tab.push_back('{4'b1111, 1'b0, 4'b0000});
      arb_tab.push_back('{4'b1111, 1'b0, 4'b0000});
      arb_tab.push_back('{4'b1111, 1'b1, 4'b1000});
      arb_tab.push_back('{4'b0000, 1'b1, 4'b0000});
      arb_tab.push_back('{4'b0000, 1'b1, 4'b0000});
      // Wrap: req3 alone, then req0/req3 alternate.
      arb_tab.push_back('{4'b1000, 1'b1, 4'b1000});
      arb_tab.push_back('{4'b1001, 1'b1, 4'b0001});
      arb_tab.push_back('{4'b1001, 1'b1, 4'b1000});
      arb_tab.push_back('{4'b1001, 1'b1, 4'b0001});
      for (int k = 0; k < 3; k++) arb_tab.push_back('{4'b0000, 1'b0, 4'b0000});

      for (int r = 0; r < 4; r++) begin
         px[r] = '0;
         py[r] = '0;
      end
      rst = 1'b1;
      req_valid = '0; rand_valid = 1'b0;
      req_x = '0; req_y = '0; rand_z = '0;

      // Reset: second cycle has requests pending, which must not be granted.
      step(4'b0000);
      drive(4'b1111, 1'b1);
      step(4'b0000);
      rst = 1'b0;
      drive(4'b0000, 1'b0);
      step(4'b0000);

      // Single request from req0, X share0=2, Y share0=3, Z=0.
      req_x[5:0] = 6'b000010;
      req_y[5:0] = 6'b000011;
      px[0] = 2'd2;
      py[0] = 2'd3;
      req_valid = 4'b0001;
      rand_valid = 1'b1;
      rand_z = '0;
      step(4'b0001);
      drive(4'b0000, 1'b0);
      for (int k = 0; k < 3; k++) step(4'b0000);

      // Table-driven arbitration sequences.
      for (int r = 0; r < 4; r++) set_req(r, 2'(r), 2'(3 - r));
      foreach (arb_tab[i]) begin
         drive(arb_tab[i].vld, arb_tab[i].rv);
         step(arb_tab[i].exp);
      end

      // Reset while req1's operation is in flight.
      drive(4'b0010, 1'b1);
      step(4'b0010);
      rst = 1'b1;
      step(4'b0000);
      rst = 1'b0;
      drive(4'b0000, 1'b1);
      for (int k = 0; k < 3; k++) step(4'b0000);
      drive(4'b1111, 1'b1);
      step(4'b0001);
      drive(4'b0000, 1'b0);
      for (int k = 0; k < 3; k++) step(4'b0000);

      // All 16 operand pairs, back-to-back, non-granted requesters carry junk.
      for (int k = 0; k < 16; k++) begin
         for (int r = 0; r < 4; r++) begin
            req_x[r*6 +: 6] = 6'($urandom);
            req_y[r*6 +: 6] = 6'($urandom);
         end
         set_req(k % 4, mul_tab[k].x, mul_tab[k].y);
         drive(4'(1 << (k % 4)), 1'b1);
         step(4'(1 << (k % 4)));
      end
      drive(4'b0000, 1'b0);
      for (int k = 0; k < 4; k++) step(4'b0000);

      check("sb_empty", 32'(sbq.size()), 32'(0));
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout want completion");
      $fatal(1);
   end

endmodule
